// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Dynamic branch predictor and redirect generator for the five-stage core.
// A direct-mapped table of 2-bit saturating counters with tags and targets
// (BHT + BTB) is looked up combinationally by the IF stage and trained by
// resolved outcomes from EX. A mispredict produces a registered one-cycle
// redirect carrying the corrected PC. Resolved-branch and mispredict counts
// saturate at all-ones.
//
// Ports:
//   clk             core clock, rising edge
//   rst             asynchronous active-low reset
//   lk_pc           IF fetch PC to predict
//   lk_taken        predicted taken for lk_pc (combinational)
//   lk_target       predicted next fetch PC (combinational)
//   upd_valid       one-cycle pulse: a branch/jump resolved in EX
//   upd_pc          PC of the resolved instruction
//   upd_taken       actual outcome
//   upd_target      actual taken target
//   upd_mispredict  EX found the prediction wrong (qualified by upd_valid)
//   redirect_valid  registered pulse: fetch restarts at redirect_pc
//   redirect_pc     corrected fetch PC (holds between pulses)
//   stat_branches   resolved branches since reset
//   stat_misses     mispredictions since reset
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_taken,
    output logic [ADDR_W-1:0] lk_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispredict,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  stat_branches,
    output logic [CNT_W-1:0]  stat_misses
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = ADDR_W - INDEX_BITS - 2;

    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [1:0]        CTR_INIT = 2'b01;
    localparam logic [1:0]        CTR_ALLOC = 2'b10;

    // Saturating 2-bit counter step up.
    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : (c + 2'b01);
    endfunction

    // Saturating 2-bit counter step down.
    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : (c - 2'b01);
    endfunction

    logic [1:0]        ctr_r    [ENTRIES];
    logic [TAG_W-1:0]  tag_r    [ENTRIES];
    logic [ADDR_W-1:0] target_r [ENTRIES];
    logic [ENTRIES-1:0] valid_r;

    logic              redirect_valid_r;
    logic [ADDR_W-1:0] redirect_pc_r;
    logic [CNT_W-1:0]  stat_branches_r;
    logic [CNT_W-1:0]  stat_misses_r;

    logic [INDEX_BITS-1:0] lk_idx_s;
    logic [TAG_W-1:0]      lk_tag_s;
    logic                  lk_hit_s;
    logic [INDEX_BITS-1:0] upd_idx_s;
    logic [TAG_W-1:0]      upd_tag_s;
    logic                  upd_hit_s;

    // Lookup: zero-latency prediction from the current table contents.
    always_comb begin
        lk_idx_s  = lk_pc[INDEX_BITS+1:2];
        lk_tag_s  = lk_pc[ADDR_W-1:INDEX_BITS+2];
        lk_hit_s  = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
        lk_taken  = lk_hit_s && ctr_r[lk_idx_s][1];
        if (lk_taken) begin
            lk_target = target_r[lk_idx_s];
        end else begin
            lk_target = lk_pc + PC_STEP;
        end
    end

    // Update-side address decode and hit detection.
    always_comb begin
        upd_idx_s = upd_pc[INDEX_BITS+1:2];
        upd_tag_s = upd_pc[ADDR_W-1:INDEX_BITS+2];
        upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    end

    // Table training: counters move on hits, taken misses allocate a fresh entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i]    <= CTR_INIT;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {ADDR_W{1'b0}};
            end
        end else if (upd_valid) begin
            if (upd_hit_s) begin
                if (upd_taken) begin
                    ctr_r[upd_idx_s]    <= ctr_inc(ctr_r[upd_idx_s]);
                    target_r[upd_idx_s] <= upd_target;
                end else begin
                    ctr_r[upd_idx_s] <= ctr_dec(ctr_r[upd_idx_s]);
                end
            end else if (upd_taken) begin
                // Not-taken misses are never allocated so cold branches stay cheap.
                valid_r[upd_idx_s]  <= 1'b1;
                tag_r[upd_idx_s]    <= upd_tag_s;
                target_r[upd_idx_s] <= upd_target;
                ctr_r[upd_idx_s]    <= CTR_ALLOC;
            end
        end
    end

    // Redirect: one-cycle pulse after a qualified mispredict; PC holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= {ADDR_W{1'b0}};
        end else if (upd_valid && upd_mispredict) begin
            redirect_valid_r <= 1'b1;
            redirect_pc_r    <= upd_taken ? upd_target : (upd_pc + PC_STEP);
        end else begin
            redirect_valid_r <= 1'b0;
        end
    end

    // Statistics: saturating counters so long runs never wrap to a small value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches_r <= {CNT_W{1'b0}};
            stat_misses_r   <= {CNT_W{1'b0}};
        end else if (upd_valid) begin
            if (stat_branches_r != CNT_MAX) begin
                stat_branches_r <= stat_branches_r + CNT_ONE;
            end
            if (upd_mispredict && (stat_misses_r != CNT_MAX)) begin
                stat_misses_r <= stat_misses_r + CNT_ONE;
            end
        end
    end

    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign stat_branches  = stat_branches_r;
    assign stat_misses    = stat_misses_r;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Directed self-checking bench for branch_predictor. A default-width instance
// and a CNT_W=4 instance share all stimulus; the narrow one shows counter
// saturation at 15.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] lk_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;

    logic        lk_taken;
    logic [31:0] lk_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_misses;

    logic        sm_lk_taken;
    logic [31:0] sm_lk_target;
    logic        sm_redirect_valid;
    logic [31:0] sm_redirect_pc;
    logic [3:0]  sm_stat_branches;
    logic [3:0]  sm_stat_misses;

    int checks_r;
    int errors_r;

    branch_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .lk_pc          (lk_pc),
        .lk_taken       (lk_taken),
        .lk_target      (lk_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stat_branches  (stat_branches),
        .stat_misses    (stat_misses)
    );

    branch_predictor #(.CNT_W(4)) dut_small (
        .clk            (clk),
        .rst            (rst),
        .lk_pc          (lk_pc),
        .lk_taken       (sm_lk_taken),
        .lk_target      (sm_lk_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .redirect_valid (sm_redirect_valid),
        .redirect_pc    (sm_redirect_pc),
        .stat_branches  (sm_stat_branches),
        .stat_misses    (sm_stat_misses)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one resolved branch for exactly one cycle.
    task automatic do_update(input logic [31:0] pc, input logic taken,
                             input logic [31:0] target, input logic misp);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = target;
        upd_mispredict = misp;
        tick();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic check_lookup(input string tag, input logic [31:0] pc,
                                input logic exp_taken, input logic [31:0] exp_target);
        lk_pc = pc;
        #1;
        check_value({tag, "_taken"},  {63'd0, lk_taken}, {63'd0, exp_taken});
        check_value({tag, "_target"}, {32'd0, lk_target}, {32'd0, exp_target});
    endtask

    task automatic check_redirect(input string tag, input logic exp_valid, input logic [31:0] exp_pc);
        check_value({tag, "_rv"}, {63'd0, redirect_valid}, {63'd0, exp_valid});
        check_value({tag, "_rpc"}, {32'd0, redirect_pc}, {32'd0, exp_pc});
    endtask

    task automatic check_stats(input string tag, input int exp_br, input int exp_ms);
        check_value({tag, "_branches"}, {32'd0, stat_branches}, 64'(exp_br));
        check_value({tag, "_misses"},   {32'd0, stat_misses},   64'(exp_ms));
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        checks_r       = 0;
        errors_r       = 0;
        rst            = 1'b0;
        lk_pc          = 32'h0000_0100;
        upd_valid      = 1'b0;
        upd_pc         = 32'h0;
        upd_taken      = 1'b0;
        upd_target     = 32'h0;
        upd_mispredict = 1'b0;

        // Reset state
        repeat (2) tick();
        check_lookup("rst_lk", 32'h100, 1'b0, 32'h104);
        check_stats("rst", 0, 0);
        check_redirect("rst", 1'b0, 32'h0);
        rst = 1'b1;
        tick();

        // First taken mispredict allocates and redirects
        do_update(32'h100, 1'b1, 32'h200, 1'b1);
        check_redirect("alloc", 1'b1, 32'h200);
        check_lookup("alloc_lk", 32'h100, 1'b1, 32'h200);
        check_stats("alloc", 1, 1);
        tick();
        check_redirect("alloc_hold", 1'b0, 32'h200);

        // Counter walks down 10->01->00->00, back-to-back
        do_update(32'h100, 1'b0, 32'h0, 1'b1);
        check_redirect("nt1", 1'b1, 32'h104);
        check_lookup("nt1_lk", 32'h100, 1'b0, 32'h104);
        do_update(32'h100, 1'b0, 32'h0, 1'b0);
        check_redirect("nt2", 1'b0, 32'h104);
        do_update(32'h100, 1'b0, 32'h0, 1'b0);
        do_update(32'h100, 1'b0, 32'h0, 1'b0);
        check_lookup("nt4_lk", 32'h100, 1'b0, 32'h104);
        // Two taken: 00->01 (still not taken) -> 10 (taken)
        do_update(32'h100, 1'b1, 32'h200, 1'b1);
        check_lookup("t1_lk", 32'h100, 1'b0, 32'h104);
        check_redirect("t1", 1'b1, 32'h200);
        do_update(32'h100, 1'b1, 32'h240, 1'b1);
        check_redirect("t2", 1'b1, 32'h240);
        check_lookup("t2_lk", 32'h100, 1'b1, 32'h240);
        check_stats("walk", 7, 4);

        // Aliasing on index 0 with different tags
        do_update(32'h100, 1'b1, 32'h240, 1'b0);
        check_lookup("alias_lk", 32'h200, 1'b0, 32'h204);
        do_update(32'h200, 1'b1, 32'h480, 1'b1);
        check_lookup("repl_new", 32'h200, 1'b1, 32'h480);
        check_lookup("repl_old", 32'h100, 1'b0, 32'h104);
        check_stats("alias", 9, 5);

        // Same-cycle lookup/update to one index sees pre-update contents
        lk_pc          = 32'h200;
        upd_valid      = 1'b1;
        upd_pc         = 32'h200;
        upd_taken      = 1'b0;
        upd_target     = 32'h0;
        upd_mispredict = 1'b1;
        #1;
        check_value("same_cycle_taken", {63'd0, lk_taken}, 64'd1);
        tick();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        check_lookup("same_after", 32'h200, 1'b0, 32'h204);
        check_redirect("same", 1'b1, 32'h204);

        // Not-taken mispredict on a cold entry: redirect to pc+4, no allocation
        do_update(32'h300, 1'b0, 32'h900, 1'b1);
        check_redirect("nt_miss", 1'b1, 32'h304);
        check_lookup("nt_miss_lk", 32'h300, 1'b0, 32'h304);
        check_stats("nt_miss", 11, 7);

        // Unqualified mispredict is ignored
        upd_valid      = 1'b0;
        upd_mispredict = 1'b1;
        upd_pc         = 32'h500;
        upd_taken      = 1'b1;
        upd_target     = 32'h700;
        tick();
        upd_mispredict = 1'b0;
        check_redirect("unqual", 1'b0, 32'h304);
        check_stats("unqual", 11, 7);

        // Asynchronous reset mid-update: immediate effect, update lost
        upd_valid      = 1'b1;
        upd_pc         = 32'h100;
        upd_taken      = 1'b1;
        upd_target     = 32'h600;
        upd_mispredict = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_stats("async_rst", 0, 0);
        check_redirect("async_rst", 1'b0, 32'h0);
        check_lookup("async_rst_lk", 32'h200, 1'b0, 32'h204);
        tick();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        rst            = 1'b1;
        tick();
        check_lookup("lost_upd", 32'h100, 1'b0, 32'h104);
        check_redirect("lost_upd", 1'b0, 32'h0);

        // Saturation: 20 mispredicting updates, narrow counters stop at 15
        for (int i = 0; i < 20; i++) begin
            do_update(32'h300, 1'b0, 32'h0, 1'b1);
        end
        check_stats("sat_wide", 20, 20);
        check_value("sat_small_branches", {60'd0, sm_stat_branches}, 64'd15);
        check_value("sat_small_misses",   {60'd0, sm_stat_misses},   64'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor and redirect generator for the five-stage core. The IF stage looks up the fetch PC and gets a taken/not-taken prediction plus next-fetch target; that prediction travels down the pipe with the instruction. The EX stage returns the resolved outcome for each branch/jump, which trains a direct-mapped BHT (2-bit saturating counters) plus BTB. On a misprediction the block issues a registered one-cycle redirect carrying the correct PC, and it keeps hit/miss statistics.

## Interface
Parameters:
- INDEX_BITS, 6, log2 of table entries (64 entries)
- ADDR_W, 32, instruction address width
- CNT_W, 32, statistics counter width

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- lk_pc  input  ADDR_W  IF-stage fetch PC to predict
- lk_taken  output  1  predicted taken for lk_pc
- lk_target  output  ADDR_W  predicted next PC for lk_pc
- upd_valid  input  1  one-cycle pulse from EX: a branch/jump resolved this cycle
- upd_pc  input  ADDR_W  PC of the resolved instruction
- upd_taken  input  1  actual outcome
- upd_target  input  ADDR_W  actual taken target
- upd_mispredict  input  1  EX found prediction wrong (qualified by upd_valid)
- redirect_valid  output  1  registered pulse: fetch must restart at redirect_pc
- redirect_pc  output  ADDR_W  corrected fetch PC
- stat_branches  output  CNT_W  resolved branches since reset
- stat_misses  output  CNT_W  mispredictions since reset

## Operation
- Addressing: idx = pc[INDEX_BITS+1:2]; tag = pc[ADDR_W-1:INDEX_BITS+2]; pc[1:0] ignored.
- Per entry: ctr (2 bits), valid (1), tag, target (ADDR_W).
- Lookup (combinational): hit = valid[idx] && tag[idx]==tag(lk_pc). lk_taken = hit && ctr[idx][1]. lk_target = lk_taken ? target[idx] : lk_pc+4 (modulo 2^ADDR_W).
- Update when upd_valid=1, entry at idx(upd_pc):
  - tag mismatch or invalid entry and upd_taken=1: allocate: valid<=1, tag<=tag(upd_pc), target<=upd_target, ctr<=2'b10.
  - tag mismatch or invalid and upd_taken=0: no change (no allocation on not-taken).
  - hit: ctr saturating +1 if upd_taken (max 2'b11), −1 otherwise (min 2'b00); if upd_taken, target<=upd_target.
- Redirect: if upd_valid && upd_mispredict, next cycle redirect_valid=1, redirect_pc = upd_taken ? upd_target : upd_pc+4; otherwise redirect_valid=0 and redirect_pc holds its previous value.
- upd_mispredict with upd_valid=0 is ignored entirely.
- Statistics: stat_branches +1 per upd_valid; stat_misses +1 per upd_valid&&upd_mispredict; both saturate at all-ones, never wrap.
- Reset (asynchronous, any time, including mid-update): all valid<=0, all ctr<=2'b01, tags/targets<=0, redirect_valid<=0, redirect_pc<=0, stat_branches<=0, stat_misses<=0. Outputs after reset: lk_taken=0, lk_target=lk_pc+4.

## Timing
- Lookup latency 0 cycles: lk_taken/lk_target follow lk_pc combinationally.
- Update written at the rising edge where upd_valid=1; visible to lookups from the next cycle.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents.
- Back-to-back updates every cycle supported, including the same index (each applied in order, saturation per step).
- Redirect latency exactly 1 cycle after the upd_valid cycle; redirect_valid is high for exactly one cycle per mispredict; consecutive mispredicts give consecutive pulses.
- No stall input: EX must assert upd_valid once per resolved instruction and never for a discarded one.

## Test plan
- Reset then lookup 0x0000_0100 -> lk_taken=0, lk_target=0x0000_0104; stats 0, redirect_valid=0.
- Update pc=0x100 taken target=0x200 mispredict=1 -> next cycle redirect_valid=1, redirect_pc=0x200; following cycle lookup 0x100 -> lk_taken=1, lk_target=0x200; stat_branches=1, stat_misses=1.
- Same entry, four not-taken updates -> ctr 10→01→00→00; lookup 0x100 gives lk_taken=0 after first; then two taken -> lk_taken=1 again.
- Alias: train 0x100 taken, lookup 0x200 (same idx, different tag) -> lk_taken=0, lk_target=0x204; taken update at 0x200 replaces entry, 0x100 now misses.
- Mispredict not-taken at 0x300 -> redirect_pc=0x304; upd_mispredict=1 with upd_valid=0 -> no redirect, stats unchanged.
- Assert rst low mid-stream with upd_valid=1 -> all state and outputs at reset values immediately, update lost; force stat counters near all-ones (CNT_W=4 build) -> saturate at 15.
